// File: rtl/gf2_poly_div_if.sv
// Operand/result handshake bundle for the GF(2) polynomial divider.
// The master drives operands and out_ready; the slave returns the results.
interface gf2_poly_div_if #(
   parameter int DW = 8
);
   localparam int NW = 2*DW - 1;

   logic          in_valid;
   logic          in_ready;
   logic [NW-1:0] dividend;
   logic [DW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [NW-1:0] quotient;
   logic [DW-2:0] remainder;
   logic          div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/gf2_poly_div.sv
// Sequential carry-less polynomial divider. The divisor is normalised so its leading
// term sits at the top of the dividend window, then one quotient bit is retired per cycle.
module gf2_poly_div #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   gf2_poly_div_if.slave bus
);
   localparam int NW = 2*DW - 1;
   localparam int PW = $clog2(NW);
   localparam int GW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

   state_t        state_q, state_d;
   logic [NW-1:0] w_q, dv_q, q_q;
   logic [PW-1:0] p_q;
   logic [GW-1:0] deg_q, deg_in;
   logic [NW-1:0] quotient_q;
   logic [DW-2:0] remainder_q;
   logic          div_by_zero_q, out_valid_q;

   logic          accept, w_bit, last_step;
   logic [NW-1:0] w_step, q_step, dv_shl;

   assign accept    = bus.in_valid && (state_q == IDLE);
   assign w_bit     = w_q[p_q];
   assign w_step    = w_bit ? (w_q ^ dv_q) : w_q;
   assign q_step    = {q_q[NW-2:0], w_bit};
   assign dv_shl    = dv_q << 1;
   assign last_step = (p_q == PW'(deg_q));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      deg_in = '0;
      for (int i = 0; i < DW; i++)
         if (bus.divisor[i]) deg_in = GW'(i);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) begin
            if (bus.divisor == '0)      state_d = DONE;
            else if (bus.divisor[DW-1]) state_d = DIV;
            else                        state_d = NORM;
         end
         NORM:    if (dv_shl[NW-1]) state_d = DIV;
         DIV:     if (last_step) state_d = DONE;
         DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: working registers are always loaded on accept before use, so they carry no reset.
   always_ff @(posedge clk) begin
      case (state_q)
         IDLE: if (accept) begin
            w_q   <= bus.dividend;
            dv_q  <= {bus.divisor, {(NW-DW){1'b0}}};
            q_q   <= '0;
            deg_q <= deg_in;
            p_q   <= PW'(NW-1);
         end
         NORM: dv_q <= dv_shl;
         DIV: begin
            w_q  <= w_step;
            q_q  <= q_step;
            dv_q <= dv_q >> 1;
            p_q  <= p_q - 1'b1;
         end
         default: ;
      endcase
   end

   // Results load on the final DIV step; a zero divisor loads its result one cycle into DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else if (state_q == DIV && last_step) begin
         out_valid_q   <= 1'b1;
         quotient_q    <= q_step;
         remainder_q   <= w_step[DW-2:0];
         div_by_zero_q <= 1'b0;
      end else if (state_q == DONE) begin
         if (!out_valid_q) begin
            out_valid_q   <= 1'b1;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = out_valid_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_gf2_poly_div.sv
// Bench for gf2_poly_div: a polynomial long-division model predicts every result and
// its latency; one negedge monitor compares the DUT against it each meaningful cycle.
module tb_gf2_poly_div;
   localparam int DW       = 8;
   localparam int NW       = 2*DW - 1;
   localparam int RW       = DW - 1;
   localparam int N_RANDOM = 2000;

   typedef struct {
      logic [NW-1:0] q;
      logic [RW-1:0] r;
      logic          dbz;
      int            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0, errors = 0;
   int   cyc = 0, acc_cyc = 0, hs_cyc = 0;
   int   n_sent = 0, n_done = 0, rdy_mode = 0;
   bit   seen_valid = 0, post_rst_chk = 0, post_hs_chk = 0;
   exp_t pend[$];
   exp_t e;
   logic [NW-1:0] mq;
   logic [RW-1:0] mr;

   gf2_poly_div_if #(.DW(DW)) bus ();
   gf2_poly_div #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int poly_deg(input logic [31:0] v);
      int d = -1;
      for (int i = 0; i < 32; i++) if (v[i]) d = i;
      return d;
   endfunction

   function automatic logic [31:0] clmul(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] acc = '0;
      for (int i = 0; i < 16; i++) if (a[i]) acc = acc ^ (b << i);
      return acc;
   endfunction

   // Schoolbook division: cancel the leading term of the running remainder each step.
   function automatic void poly_div(input logic [NW-1:0] n, input logic [DW-1:0] b,
                                    output logic [NW-1:0] q, output logic [RW-1:0] r);
      logic [31:0] rem;
      int          db;
      rem = 32'(n);
      q   = '0;
      db  = poly_deg(32'(b));
      for (int s = NW-1-db; s >= 0; s--)
         if (rem[s+db]) begin
            q[s] = 1'b1;
            rem  = rem ^ (32'(b) << s);
         end
      r = RW'(rem);
   endfunction

   function automatic exp_t expect_for(input logic [NW-1:0] n, input logic [DW-1:0] b);
      exp_t x;
      int   db;
      db    = poly_deg(32'(b));
      x.dbz = (b == '0);
      if (b == '0) begin
         x.q   = '0;
         x.r   = '0;
         x.lat = 1;
      end else begin
         poly_div(n, b, x.q, x.r);
         x.lat = (DW-1-db) + (NW-db);
      end
      return x;
   endfunction

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = ($urandom_range(0, 2) != 0);
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Inputs are driven at posedge+1, so what is seen here is what the next edge samples.
   always @(negedge clk) begin
      if (post_rst_chk) begin
         check("rst_in_ready", bus.in_ready, 1);
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_quotient", bus.quotient, 0);
         check("rst_remainder", bus.remainder, 0);
         check("rst_div_by_zero", bus.div_by_zero, 0);
         post_rst_chk = 0;
      end
      if (post_hs_chk) begin
         check("hs_in_ready", bus.in_ready, 1);
         check("hs_out_valid", bus.out_valid, 0);
         post_hs_chk = 0;
      end
      if (!rst_n) begin
         pend.delete();
         seen_valid   = 0;
         post_rst_chk = 1;
      end else begin
         if (pend.size() != 0) begin
            check("busy_in_ready", bus.in_ready, 0);
            if (bus.out_valid) begin
               if (!seen_valid) begin
                  check("latency", cyc - acc_cyc, pend[0].lat);
                  seen_valid = 1;
               end
               check("quotient", bus.quotient, pend[0].q);
               check("remainder", bus.remainder, pend[0].r);
               check("div_by_zero", bus.div_by_zero, pend[0].dbz);
               if (bus.out_ready) begin
                  hs_cyc = cyc + 1;
                  void'(pend.pop_front());
                  seen_valid  = 0;
                  post_hs_chk = 1;
                  n_done++;
               end
            end else if (cyc - acc_cyc > 64) begin
               check("result_timeout", cyc - acc_cyc, pend[0].lat);
               pend.delete();
            end
         end else begin
            check("idle_out_valid", bus.out_valid, 0);
         end
         if (bus.in_valid && bus.in_ready) begin
            pend.push_back(expect_for(bus.dividend, bus.divisor));
            acc_cyc = cyc + 1;
         end
      end
   end

   task automatic send(input logic [NW-1:0] n, input logic [DW-1:0] b);
      bit ok = 0;
      bus.dividend = n;
      bus.divisor  = b;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready && rst_n;
      end
      check("accept_seen", ok, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = NW'($urandom());
      bus.divisor  = DW'($urandom());
      n_sent++;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && pend.size() != 0; i++) @(negedge clk);
      check("drain", pend.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #950_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      poly_div(15'h4000, 8'h80, mq, mr);
      check("pin_monic_q", mq, 15'h0080);
      check("pin_monic_r", mr, 7'h00);
      poly_div(15'h0007, 8'h03, mq, mr);
      check("pin_low_q", mq, 15'h0002);
      check("pin_low_r", mr, 7'h01);
      check("pin_clmul", clmul(32'h5, 32'h3), 32'hf);
      e = expect_for(15'h4000, 8'h80); check("pin_lat_d7", e.lat, 8);
      e = expect_for(15'h0007, 8'h03); check("pin_lat_d1", e.lat, 20);
      e = expect_for(15'h1234, 8'h01); check("pin_lat_d0", e.lat, 22);
      e = expect_for(15'h1234, 8'h00); check("pin_lat_zero", e.lat, 1);
      check("pin_zero_flag", e.dbz, 1);

      send(15'h4000, 8'h80); wait_idle();
      send(15'h0007, 8'h03); wait_idle();
      send(15'h1234, 8'h00); wait_idle();
      send(15'h7fff, 8'h01); wait_idle();

      // Backpressure with a second request held pending through the whole busy period.
      rdy_mode = 2;
      send(15'h5a5a, 8'h1d);
      bus.dividend = 15'h2bcd;
      bus.divisor  = 8'h9b;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
      check("bp_valid_seen", bus.out_valid, 1);
      repeat (5) @(negedge clk);
      rdy_mode = 0;
      for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      n_sent++;
      check("second_accept_gap", acc_cyc - hs_cyc, 1);
      wait_idle();

      // Reset during the fourth DIV cycle discards the in-flight result.
      send(15'h6c3a, 8'hd5);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (30) @(negedge clk);
      @(posedge clk);
      #1;
      send(15'h3141, 8'h25); wait_idle();

      rdy_mode = 1;
      for (int k = 0; k < N_RANDOM; k++) begin
         int            db;
         logic [NW-1:0] a, n;
         logic [DW-1:0] b;
         logic [RW-1:0] r;
         db = $urandom_range(0, DW-1);
         b  = DW'((32'd1 << db) | ($urandom() & ((32'd1 << db) - 1)));
         a  = NW'($urandom() & ((32'd1 << (NW-db)) - 1));
         r  = RW'($urandom() & ((32'd1 << db) - 1));
         n  = NW'(clmul(32'(a), 32'(b))) ^ NW'(r);
         poly_div(n, b, mq, mr);
         check("model_q_rand", mq, a);
         check("model_r_rand", mr, r);
         send(n, b);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      wait_idle();
      rdy_mode = 0;
      repeat (3) @(posedge clk);

      check("ops_completed", n_done, n_sent - 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
